spi_slave_stream: RTL and testbench
===================================

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 Parameter DATA_W, default 8, SPI word width in bits, legal 4..32.
REQ-002 Parameter CPOL, default 0, SCLK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter SYNC_STAGES, default 3, synchronizer depth for i_SCLK/i_SS_N, legal 2..4.
REQ-005 Ports (clock and reset first):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_SCLK  in  1  SPI clock from master
- i_MOSI  in  1  master-out data
- i_SS_N  in  1  slave select, active low
- o_MISO  out  1  slave-out data
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty
- rx_data  out  DATA_W  last complete received word
- rx_valid  out  1  one-cycle pulse, new rx_data
- rx_first  out  1  high with rx_valid when the word is the first of the frame
- frame_done  out  1  one-cycle pulse at end of frame
- frame_words  out  8  words completed in the last frame
- frame_err  out  1  one-cycle pulse, frame ended mid-word
- tx_underrun  out  1  one-cycle pulse, load occurred with holding register empty
REQ-006 One clock; reset is asynchronous and active-high.

Function
REQ-007 i_SCLK and i_SS_N SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the two oldest stages; i_MOSI SHALL be sampled unsynchronized at the detected sample edge.
REQ-008 Leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the sample edge is per CPHA; the shift edge is the other edge.
REQ-009 Frame active SHALL equal the synchronized i_SS_N being low; while inactive, the bit counter SHALL be held at 0 and SCLK edges ignored.
REQ-010 Each sample edge SHALL shift i_MOSI into the rx shift register MSB-first and increment bit_cnt; when bit_cnt reaches DATA_W-1, the next clock SHALL assert rx_valid for one cycle, update rx_data, and wrap bit_cnt to 0.
REQ-011 rx_first SHALL be high only with the first rx_valid after frame start.
REQ-012 A tx load SHALL occur at each shift edge with bit_cnt==0 and, for CPHA=0 only, also on the clk after frame start; every other shift edge SHALL shift the tx register left, filling with 0.
REQ-013 A load SHALL take the holding register and set tx_ready; if the holding register is empty, the load SHALL use all-zero data and pulse tx_underrun.
REQ-014 tx_valid AND tx_ready SHALL write tx_data into the holding register on that clk; a load in the same cycle SHALL see the pre-write state (no bypass).
REQ-015 o_MISO SHALL equal tx register MSB while the frame is active, and 0 otherwise.
REQ-016 On frame end (synchronized SS_N rising), the next clk SHALL pulse frame_done and latch frame_words; if bit_cnt!=0, the same clk SHALL also pulse frame_err and discard the partial word (no rx_valid).
REQ-017 The frame word counter SHALL saturate at 255 and clear at frame start.
REQ-018 The design SHALL operate correctly for SCLK at most clk/8.

Reset
REQ-019 Reset SHALL clear all outputs, the shift registers, bit_cnt and counters to 0, set tx_ready=1, and preset synchronizer SS_N stages to 1 and SCLK stages to CPOL.
REQ-020 Reset during a frame SHALL abandon it with no frame_done/frame_err; the block SHALL wait for a fresh SS_N fall.

Structure
REQ-021 Package spi_pkg SHALL hold the default constants (DATA_W, SYNC_STAGES) and the typedef for the frame state (IDLE, ACTIVE, END).
REQ-022 Sub-module spi_sync_edge SHALL implement the synchronizer plus rise/fall detection, instanced once for SCLK and once for SS_N.

Verification
REQ-023 Mode 0, DATA_W=8, holding register=0xA5, master sends 0x3C -> MISO shows 0xA5; rx_data=0x3C, rx_valid and rx_first pulse; frame_done with frame_words=1.
REQ-024 Each of modes 1/2/3, master sends 0x96 and 0x0F -> two rx_valid pulses with correct data; rx_first on the first only; frame_words=2.
REQ-025 No tx_valid before the frame -> tx_underrun pulses at the first load; MISO=0 for all bits.
REQ-026 SS_N raised after 5 of 8 bits -> frame_err and frame_done pulse together; frame_words=0; no rx_valid.
REQ-027 DATA_W=16, 300-word frame -> 300 rx_valid pulses; frame_words=255.
REQ-028 Reset asserted mid-word -> all outputs 0, tx_ready=1; next frame with 0x55 receives correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared defaults and frame-state encoding for the SPI slave stream block.
package spi_pkg;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 3;

  typedef logic [1:0] frame_state_t;
  localparam frame_state_t ST_IDLE   = 2'd0;
  localparam frame_state_t ST_ACTIVE = 2'd1;
  localparam frame_state_t ST_END    = 2'd2;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detect on its two oldest stages.
// primed goes high once every stage holds real input rather than the reset preset.
module spi_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic primed
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] prime_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {STAGES{RST_VAL}};
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d};
      prime_q <= {prime_q[STAGES-2:0], 1'b1};
    end
  end

  assign q      = sync_q[STAGES-2];
  assign rise   =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall   = ~sync_q[STAGES-2] &  sync_q[STAGES-1];
  assign primed = prime_q[STAGES-1];
endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with streaming tx holding register and rx word output, all logic in clk domain.
// SCLK/SS_N are oversampled; MOSI is taken raw at the detected sample edge.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_SCLK,
  input  logic              i_MOSI,
  input  logic              i_SS_N,
  output logic              o_MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_first,
  output logic              frame_done,
  output logic [7:0]        frame_words,
  output logic              frame_err,
  output logic              tx_underrun
);
  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            SCLK_IDLE = (CPOL != 0);

  logic unused_sclk_lvl;
  logic sclk_rise, sclk_fall, sclk_primed;
  logic ss_q, ss_rise, ss_fall, ss_primed;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .d      (i_SCLK),
    .q      (unused_sclk_lvl),
    .rise   (sclk_rise),
    .fall   (sclk_fall),
    .primed (sclk_primed)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk    (clk),
    .reset  (reset),
    .d      (i_SS_N),
    .q      (ss_q),
    .rise   (ss_rise),
    .fall   (ss_fall),
    .primed (ss_primed)
  );

  frame_state_t      state;
  logic              armed;
  logic              first_pend;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        word_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] hold;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic active, start, load, hold_wr;

  assign lead_edge   = sclk_primed & ((CPOL != 0) ? sclk_fall : sclk_rise);
  assign trail_edge  = sclk_primed & ((CPOL != 0) ? sclk_rise : sclk_fall);
  assign sample_edge = (CPHA == 0) ? lead_edge  : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  assign active  = (state == ST_ACTIVE);
  // armed only after SS_N has been seen high post-reset, so a frame cut by reset is not resumed
  assign start   = (state == ST_IDLE) & armed & ss_fall;
  assign load    = ((CPHA == 0) & start) |
                   (active & ~ss_rise & shift_edge & (bit_cnt == '0));
  assign hold_wr = tx_valid & tx_ready;

  assign o_MISO = active & tx_shift[DATA_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      first_pend  <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      if (ss_primed && ss_q) armed <= 1'b1;

      // load sees the holding register as it was before any same-cycle write
      if (load) begin
        tx_shift    <= tx_ready ? '0 : hold;
        tx_underrun <= tx_ready;
      end else if (active && !ss_rise && shift_edge) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      if (hold_wr) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (load) begin
        tx_ready <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (start) begin
            state      <= ST_ACTIVE;
            word_cnt   <= '0;
            first_pend <= 1'b1;
            rx_shift   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state       <= ST_END;
            frame_done  <= 1'b1;
            frame_words <= word_cnt;
            frame_err   <= (bit_cnt != '0);
            bit_cnt     <= '0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-2:0], i_MOSI};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_data    <= {rx_shift[DATA_W-2:0], i_MOSI};
              rx_valid   <= 1'b1;
              rx_first   <= first_pend;
              first_pend <= 1'b0;
              word_cnt   <= (word_cnt == 8'hFF) ? word_cnt : word_cnt + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench: four 8-bit instances (modes 0..3) plus one 16-bit mode-0 instance.
module tb_spi_slave_stream;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mosi = 1'b0;
  logic [4:0] sclk = 5'b01100;
  logic [4:0] ss_n = 5'b11111;
  logic [4:0] tx_valid = '0;
  logic [7:0]  tx_data8 = '0;
  logic [15:0] tx_data16 = '0;

  logic [4:0] miso, tx_ready, rxv, rxf, fd, fe, und;
  logic [7:0]  rx_data8 [4];
  logic [15:0] rx_data16;
  logic [7:0]  fw [5];
  logic [31:0] rx_word [5];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_m
    spi_slave_stream #(.DATA_W(8), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(3)) u_dut (
      .clk(clk), .reset(reset), .i_SCLK(sclk[m]), .i_MOSI(mosi), .i_SS_N(ss_n[m]),
      .o_MISO(miso[m]), .tx_data(tx_data8), .tx_valid(tx_valid[m]), .tx_ready(tx_ready[m]),
      .rx_data(rx_data8[m]), .rx_valid(rxv[m]), .rx_first(rxf[m]), .frame_done(fd[m]),
      .frame_words(fw[m]), .frame_err(fe[m]), .tx_underrun(und[m])
    );
    assign rx_word[m] = {24'b0, rx_data8[m]};
  end

  spi_slave_stream #(.DATA_W(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(3)) u_dut16 (
    .clk(clk), .reset(reset), .i_SCLK(sclk[4]), .i_MOSI(mosi), .i_SS_N(ss_n[4]),
    .o_MISO(miso[4]), .tx_data(tx_data16), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
    .rx_data(rx_data16), .rx_valid(rxv[4]), .rx_first(rxf[4]), .frame_done(fd[4]),
    .frame_words(fw[4]), .frame_err(fe[4]), .tx_underrun(und[4])
  );
  assign rx_word[4] = {16'b0, rx_data16};

  // pulse monitors
  int rxv_n [5], rxf_n [5], fd_n [5], fe_n [5], fdfe_n [5], und_n [5];
  logic [31:0] rx_last [5], rx_prev [5];
  initial for (int i = 0; i < 5; i++) begin
    rxv_n[i] = 0; rxf_n[i] = 0; fd_n[i] = 0; fe_n[i] = 0; fdfe_n[i] = 0; und_n[i] = 0;
    rx_last[i] = '0; rx_prev[i] = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv[i]) begin
        rxv_n[i]++;
        rx_prev[i] = rx_last[i];
        rx_last[i] = rx_word[i];
      end
      if (rxf[i]) rxf_n[i]++;
      if (fd[i]) fd_n[i]++;
      if (fe[i]) fe_n[i]++;
      if (fd[i] && fe[i]) fdfe_n[i]++;
      if (und[i]) und_n[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input int idx, input logic [15:0] d);
    tx_data8 = d[7:0];
    tx_data16 = d;
    tx_valid[idx] = 1'b1;
    wait_clk(1);
    tx_valid[idx] = 1'b0;
    wait_clk(1);
  endtask

  task automatic frame_begin(input int idx);
    ss_n[idx] = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end(input int idx);
    wait_clk(HALF);
    ss_n[idx] = 1'b1;
    wait_clk(10);
  endtask

  // master side: MISO is captured just before each sample edge
  task automatic xfer(input int idx, input int nbits, input logic [31:0] w, output logic [31:0] r);
    logic pol, pha;
    pol = (idx < 4) ? logic'(idx / 2) : 1'b0;
    pha = (idx < 4) ? logic'(idx % 2) : 1'b0;
    r = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (!pha) begin
        mosi = w[b];
        wait_clk(HALF);
        r = {r[30:0], miso[idx]};
        sclk[idx] = ~pol;
        wait_clk(HALF);
        sclk[idx] = pol;
      end else begin
        sclk[idx] = ~pol;
        mosi = w[b];
        wait_clk(HALF);
        r = {r[30:0], miso[idx]};
        sclk[idx] = pol;
        wait_clk(HALF);
      end
    end
  endtask

  initial begin
    logic [31:0] r0, r1;
    int b_rxv, b_rxf, b_fd, b_fe, b_fdfe, b_und;

    // reset state
    wait_clk(3);
    #1;
    check("rst_rx_valid", {27'b0, rxv}, 32'h0);
    check("rst_rx_data", rx_word[0], 32'h0);
    check("rst_tx_ready", {27'b0, tx_ready}, 32'h1f);
    check("rst_miso", {27'b0, miso}, 32'h0);
    check("rst_frame_words", {24'b0, fw[0]}, 32'h0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(10);

    // mode 0 basic word
    load_tx(0, 16'h00A5);
    check("m0_tx_ready_full", {31'b0, tx_ready[0]}, 32'h0);
    b_rxv = rxv_n[0]; b_rxf = rxf_n[0]; b_fd = fd_n[0]; b_fe = fe_n[0];
    frame_begin(0);
    check("m0_tx_ready_after_load", {31'b0, tx_ready[0]}, 32'h1);
    xfer(0, 8, 32'h3C, r0);
    frame_end(0);
    check("m0_miso", r0, 32'hA5);
    check("m0_rx_data", rx_last[0], 32'h3C);
    check("m0_rx_valid_n", rxv_n[0] - b_rxv, 1);
    check("m0_rx_first_n", rxf_n[0] - b_rxf, 1);
    check("m0_frame_done_n", fd_n[0] - b_fd, 1);
    check("m0_frame_err_n", fe_n[0] - b_fe, 0);
    check("m0_frame_words", {24'b0, fw[0]}, 32'd1);

    // modes 1..3, two words each
    for (int m = 1; m < 4; m++) begin
      load_tx(m, 16'h005A);
      b_rxv = rxv_n[m]; b_rxf = rxf_n[m]; b_fd = fd_n[m];
      frame_begin(m);
      xfer(m, 8, 32'h96, r0);
      xfer(m, 8, 32'h0F, r1);
      frame_end(m);
      check($sformatf("m%0d_miso0", m), r0, 32'h5A);
      check($sformatf("m%0d_miso1", m), r1, 32'h00);
      check($sformatf("m%0d_rx0", m), rx_prev[m], 32'h96);
      check($sformatf("m%0d_rx1", m), rx_last[m], 32'h0F);
      check($sformatf("m%0d_rx_valid_n", m), rxv_n[m] - b_rxv, 2);
      check($sformatf("m%0d_rx_first_n", m), rxf_n[m] - b_rxf, 1);
      check($sformatf("m%0d_frame_done_n", m), fd_n[m] - b_fd, 1);
      check($sformatf("m%0d_frame_words", m), {24'b0, fw[m]}, 32'd2);
    end

    // underrun: empty holding register at frame start
    b_und = und_n[0];
    frame_begin(0);
    check("und_first_load", und_n[0] - b_und, 1);
    xfer(0, 8, 32'hC3, r0);
    frame_end(0);
    check("und_miso_zero", r0, 32'h0);
    check("und_rx_data", rx_last[0], 32'hC3);

    // frame cut after 5 bits
    b_rxv = rxv_n[0]; b_fd = fd_n[0]; b_fe = fe_n[0]; b_fdfe = fdfe_n[0];
    frame_begin(0);
    xfer(0, 5, 32'h1F, r0);
    frame_end(0);
    check("cut_frame_err_n", fe_n[0] - b_fe, 1);
    check("cut_frame_done_n", fd_n[0] - b_fd, 1);
    check("cut_together_n", fdfe_n[0] - b_fdfe, 1);
    check("cut_rx_valid_n", rxv_n[0] - b_rxv, 0);
    check("cut_frame_words", {24'b0, fw[0]}, 32'd0);

    // 16-bit, 300 words: word counter saturates
    b_rxv = rxv_n[4]; b_rxf = rxf_n[4];
    frame_begin(4);
    for (int i = 0; i < 300; i++) xfer(4, 16, 32'hA000 + i, r0);
    frame_end(4);
    check("w16_rx_valid_n", rxv_n[4] - b_rxv, 300);
    check("w16_rx_first_n", rxf_n[4] - b_rxf, 1);
    check("w16_last_word", rx_last[4], 32'hA12B);
    check("w16_frame_words", {24'b0, fw[4]}, 32'd255);

    // reset in the middle of a word
    load_tx(0, 16'h0077);
    b_fd = fd_n[0]; b_fe = fe_n[0];
    frame_begin(0);
    xfer(0, 3, 32'h7, r0);
    reset = 1'b1;
    #1;
    check("mid_rst_rx_data", rx_word[0], 32'h0);
    check("mid_rst_frame_words", {24'b0, fw[0]}, 32'h0);
    check("mid_rst_tx_ready", {31'b0, tx_ready[0]}, 32'h1);
    check("mid_rst_miso", {31'b0, miso[0]}, 32'h0);
    check("mid_rst_pulses", {28'b0, rxv[0], fd[0], fe[0], und[0]}, 32'h0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    ss_n[0] = 1'b1;
    wait_clk(10);
    check("mid_rst_no_frame_done", fd_n[0] - b_fd, 0);
    check("mid_rst_no_frame_err", fe_n[0] - b_fe, 0);
    b_rxv = rxv_n[0]; b_rxf = rxf_n[0];
    frame_begin(0);
    xfer(0, 8, 32'h55, r0);
    frame_end(0);
    check("post_rst_rx_data", rx_last[0], 32'h55);
    check("post_rst_rx_valid_n", rxv_n[0] - b_rxv, 1);
    check("post_rst_rx_first_n", rxf_n[0] - b_rxf, 1);
    check("post_rst_frame_words", {24'b0, fw[0]}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
